// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC generator feeding the program counter register.
// It sequences BOOT -> RUN -> HALT, selects the next PC from stall, return,
// call, jump, branch and sequential requests, and owns a circular
// return-address stack (RAS).
// Optional build macro: PC_SEQ_WRAP_DETECT_EN adds the sticky pc_wrap output.
// No valid/ready handshakes exist here. Every request input is sampled
// combinationally in the cycle it is asserted, and its effect on registered
// state lands at the next rising clock edge.
module pc_sequencer #(
  parameter int AW        = 6,
  parameter int RAS_DEPTH = 4,
  parameter int RESET_VEC = 0,
  localparam int PW       = $clog2(RAS_DEPTH),
  localparam int DW       = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] pc_in,
  input  logic          stall,
  input  logic          halt_req,
  input  logic          resume,
  input  logic          branch_taken,
  input  logic [AW-1:0] branch_off,
  input  logic          jump,
  input  logic [AW-1:0] jump_addr,
  input  logic          call,
  input  logic          ret,
  output logic [AW-1:0] target,
  output logic [1:0]    state,
  output logic [DW-1:0] ras_depth,
  output logic          ras_ovf,
  output logic          ras_unf
`ifdef PC_SEQ_WRAP_DETECT_EN
  ,
  output logic          pc_wrap
`endif
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [AW-1:0] RV   = AW'(RESET_VEC);
  localparam logic [DW-1:0] FULL = DW'(RAS_DEPTH);

  // Registered state
  state_t        r_state;
  logic [PW-1:0] r_wr_ptr;   // next slot to write; top entry is r_wr_ptr-1
  logic [DW-1:0] r_depth;
  logic          r_ovf;
  logic          r_unf;
  logic [AW-1:0] r_stack [RAS_DEPTH];

  // Combinational decisions
  state_t        w_next_state;
  logic [AW-1:0] w_target;
  logic          w_push;
  logic          w_pop;
  logic          w_set_ovf;
  logic          w_set_unf;
  logic [AW-1:0] w_pc_inc;
  logic [AW-1:0] w_pc_br;
  logic [PW-1:0] w_top_idx;
  logic [AW-1:0] w_top_val;
  logic          w_full;
  logic          w_empty;
`ifdef PC_SEQ_WRAP_DETECT_EN
  logic          w_seq_inc;   // this cycle uses the pc_in+1 path
  logic          r_wrap;
`endif

  assign w_pc_inc  = pc_in + AW'(1);
  assign w_pc_br   = pc_in + branch_off;
  assign w_top_idx = r_wr_ptr - PW'(1);
  assign w_top_val = r_stack[w_top_idx];
  assign w_full    = (r_depth == FULL);
  assign w_empty   = (r_depth == '0);

  // Next-state, target selection and stack control, priority-encoded in RUN
  always_comb begin
    w_next_state = r_state;
    w_target     = pc_in;
    w_push       = 1'b0;
    w_pop        = 1'b0;
    w_set_ovf    = 1'b0;
    w_set_unf    = 1'b0;
`ifdef PC_SEQ_WRAP_DETECT_EN
    w_seq_inc    = 1'b0;
`endif
    case (r_state)
      ST_BOOT: begin
        w_target     = RV;
        w_next_state = ST_RUN;
      end
      ST_RUN: begin
        if (stall) begin
          // Hold the PC; halt and all redirects wait for the stall to clear.
          w_target = pc_in;
        end else begin
          if (ret) begin
            w_pop = 1'b1;
            if (!w_empty) begin
              w_target = w_top_val;
            end else begin
              w_target  = w_pc_inc;
              w_set_unf = 1'b1;
`ifdef PC_SEQ_WRAP_DETECT_EN
              w_seq_inc = 1'b1;
`endif
            end
          end else if (call) begin
            w_push    = 1'b1;
            w_target  = jump_addr;
            w_set_ovf = w_full;
`ifdef PC_SEQ_WRAP_DETECT_EN
            w_seq_inc = 1'b1;
`endif
          end else if (jump) begin
            w_target = jump_addr;
          end else if (branch_taken) begin
            w_target = w_pc_br;
          end else begin
            w_target = w_pc_inc;
`ifdef PC_SEQ_WRAP_DETECT_EN
            w_seq_inc = 1'b1;
`endif
          end
          if (halt_req) begin
            w_next_state = ST_HALT;
          end
        end
      end
      ST_HALT: begin
        // Target stays pc_in, including the cycle resume is seen.
        w_target = pc_in;
        if (resume) begin
          w_next_state = ST_RUN;
        end
      end
      default: begin
        w_target     = RV;
        w_next_state = ST_BOOT;
      end
    endcase
    if (!rst_n) begin
      w_target = RV;
    end
  end

  // State, stack pointer, depth and sticky flags with asynchronous reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_BOOT;
      r_wr_ptr <= '0;
      r_depth  <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_push) begin
        // When full, the write slot holds the oldest entry and is overwritten.
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (!w_full) begin
          r_depth <= r_depth + DW'(1);
        end
      end else if (w_pop && !w_empty) begin
        r_wr_ptr <= w_top_idx;
        r_depth  <= r_depth - DW'(1);
      end
      if (w_set_ovf) begin
        r_ovf <= 1'b1;
      end
      if (w_set_unf) begin
        r_unf <= 1'b1;
      end
    end
  end

  // Stack storage: contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_stack[r_wr_ptr] <= w_pc_inc;
    end
  end

`ifdef PC_SEQ_WRAP_DETECT_EN
  // Sticky flag for a sequential increment rolling from all-ones to zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else if (w_seq_inc && (pc_in == '1)) begin
      r_wrap <= 1'b1;
    end
  end
  assign pc_wrap = r_wrap;
`endif

  assign target    = w_target;
  assign state     = r_state;
  assign ras_depth = r_depth;
  assign ras_ovf   = r_ovf;
  assign ras_unf   = r_unf;

endmodule
